led_share_arbiter: RTL
======================

Name: led_share_arbiter

Overview:
- Time-slice arbiter that shares the board's 8 user LEDs between several pattern sources: counter demos, status indicators and debug taps.
- Sits between the sources and the LED inversion stage at the board top.
- Each source requests ownership. A round-robin scheduler grants one owner at a time, holds the grant until the owner drops its request or its time slice expires, and drives the owner's pattern out registered.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SLICE_CYCLES, 50000000, maximum grant length in clk cycles (1 s at 50 MHz); must be >= 2.
- CNT_W, 26, slice counter width; 2**CNT_W must be >= SLICE_CYCLES.
- IDLE_PATTERN, 8'h00, LED value driven when nobody owns the LEDs (active-high, before board inversion).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-source ownership request, level-sensitive.
- pattern  in  NUM_REQ*8  source i pattern on bits [8i+7:8i].
- grant  out  NUM_REQ  one-hot (or zero) current owner.
- owner_valid  out  1  high while some source owns the LEDs.
- owner_idx  out  3  index of the current owner; holds the last owner when owner_valid is low.
- led_out  out  8  registered LED pattern (active-high).

Behaviour:
- One clock and one reset. Reset is asynchronous and active-high; all flops clear immediately on reset assertion.
- Reset values:
  - grant=0, owner_valid=0, led_out=IDLE_PATTERN, slice_cnt=0, state=IDLE.
  - last_owner=NUM_REQ-1, so req[0] wins first.
- States: IDLE and OWN.
- IDLE:
  - If req is nonzero, pick the first set bit scanning from last_owner+1 upward with wrap. Register grant, owner_idx and last_owner; go to OWN; clear slice_cnt.
  - Latency is 1 cycle from req rising to grant rising.
  - If req is zero, stay in IDLE.
- OWN:
  - slice_cnt increments every cycle.
  - Release occurs when req[owner]=0, or when slice_cnt==SLICE_CYCLES-1 (slice expiry).
  - On release, re-arbitrate in the same cycle, scanning from owner+1 with wrap. The current owner is considered last, and only if it is still requesting.
  - If the scan finds a winner, register it directly (no dead cycle) and clear slice_cnt. If it finds none, go to IDLE with grant=0.
  - Slice expiry with only the owner requesting re-grants the same owner; slice_cnt restarts from 0.
- led_out:
  - Registered each cycle.
  - Equals pattern of the owner in the cycle after grant is visible (2 cycles after the req edge).
  - Equals IDLE_PATTERN the cycle after owner_valid falls.
  - Pattern changes from the owner propagate with 1 cycle latency.
- Simultaneous requests are resolved strictly by rotating priority. No requester waits more than (NUM_REQ-1) slices.
- A requester that drops and re-raises req within one cycle while owner is treated as a release followed by a new request; normal round-robin applies.
- Reset mid-grant: everything returns to reset values asynchronously. The first grant after reset goes to the lowest-index requester.
- Request bits above NUM_REQ do not exist. owner_idx is zero-extended.

Decomposition:
- Shared package holds:
  - LED_W=8.
  - State encoding constants ST_IDLE and ST_OWN.
  - The default SLICE_CYCLES for 50 MHz.
- One combinational sub-module, rr_pick:
  - Inputs: req vector and start index.
  - Outputs: found flag and winner index.
  - Rotate-then-priority-encode; reused by other arbiters in the design.

Test Plan:
- Run all tests with SLICE_CYCLES=4 and NUM_REQ=4.
- Reset then idle, req=0000:
  - grant=0000, owner_valid=0, led_out=8'h00 throughout.
- Single source, req=0100 with pattern[2]=8'hA5:
  - grant=0100 one cycle later; led_out=8'hA5 one cycle after that.
  - Grant re-issued to source 2 every 4 cycles with no gap.
- Contention, req=1111 held with patterns 11,22,33,44:
  - grant sequence 0001,0010,0100,1000,0001, each lasting exactly 4 cycles.
  - led_out follows with 1 cycle lag.
- Early release: owner 1 drops req after 2 cycles while req[3]=1:
  - Next cycle grant=1000, with no idle cycle.
- Owner drops req and no other requester:
  - Next cycle grant=0000, owner_valid=0; led_out=IDLE_PATTERN one cycle later.
- Reset asserted asynchronously mid-grant (between clk edges) with req=1010:
  - grant=0 and led_out=8'h00 immediately.
  - After release, grant=0010 first.

Source files
------------

// File: rtl/led_share_arbiter_pkg.sv
// Shared constants for the LED time-slice arbiter and its round-robin picker.
package led_share_arbiter_pkg;
  localparam int LED_W = 8;
  localparam int IDX_W = 3;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;
  localparam int DEFAULT_SLICE_CYCLES = 50_000_000;
  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/led_share_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or after start, wrapping.
module rr_pick
  import led_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);
  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ:0]     seen;
  logic [IDX_W-1:0]     kacc [NUM_REQ+1];
  logic [IDX_W:0]       sum;

  // Rotating a doubled vector puts requester 'start' at bit 0.
  assign dbl = {req, req};
  assign rot = NUM_REQ'(dbl >> start);
  assign seen[0] = 1'b0;
  assign kacc[0] = '0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_prio
    assign seen[gi+1] = seen[gi] | rot[gi];
    assign kacc[gi+1] = (rot[gi] && !seen[gi]) ? IDX_W'(gi) : kacc[gi];
  end

  assign found = seen[NUM_REQ];
  assign sum   = {1'b0, start} + {1'b0, kacc[NUM_REQ]};
  assign idx   = (sum >= N_L) ? IDX_W'(sum - N_L) : IDX_W'(sum);
endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin time-slice arbiter sharing the 8 user LEDs between pattern sources.
module led_share_arbiter
  import led_share_arbiter_pkg::*;
#(
  parameter int           NUM_REQ      = 4,
  parameter int           SLICE_CYCLES = DEFAULT_SLICE_CYCLES,
  parameter int           CNT_W        = 26,
  parameter logic [7:0]   IDLE_PATTERN = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] pattern,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     owner_valid,
  output logic [IDX_W-1:0]         owner_idx,
  output logic [LED_W-1:0]         led_out
);
  localparam logic [CNT_W-1:0] SLICE_LAST = CNT_W'(SLICE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  logic                 state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     last_owner_q, last_owner_d;
  logic [CNT_W-1:0]     slice_cnt_q, slice_cnt_d;
  logic [LED_W-1:0]     led_out_q, led_out_d;

  logic [7:0]           req_ext;
  logic [LED_W-1:0]     pat_arr [8];
  logic [IDX_W-1:0]     pick_start;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   grant_win;
  logic                 rel_now;

  assign req_ext = 8'(req);

  for (genvar gi = 0; gi < 8; gi++) begin : g_pat
    if (gi < NUM_REQ) begin : g_real
      assign pat_arr[gi] = pattern[gi*LED_W +: LED_W];
    end else begin : g_none
      assign pat_arr[gi] = IDLE_PATTERN;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_win
    assign grant_win[gi] = pick_found && (pick_idx == IDX_W'(gi));
  end

  // Scanning from owner+1 with wrap naturally leaves the current owner last.
  assign pick_start = (last_owner_q == LAST_IDX) ? '0 : last_owner_q + IDX_W'(1);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    slice_cnt_d  = slice_cnt_q;
    led_out_d    = (state_q == ST_OWN) ? pat_arr[last_owner_q] : IDLE_PATTERN;
    rel_now      = (state_q == ST_IDLE) || !req_ext[last_owner_q] ||
                   (slice_cnt_q == SLICE_LAST);
    if (!rel_now) begin
      slice_cnt_d = slice_cnt_q + CNT_W'(1);
    end else if (pick_found) begin
      state_d      = ST_OWN;
      grant_d      = grant_win;
      last_owner_d = pick_idx;
      slice_cnt_d  = '0;
    end else begin
      state_d     = ST_IDLE;
      grant_d     = '0;
      slice_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_owner_q <= LAST_IDX;
      slice_cnt_q  <= '0;
      led_out_q    <= IDLE_PATTERN;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      slice_cnt_q  <= slice_cnt_d;
      led_out_q    <= led_out_d;
    end
  end

  assign grant       = grant_q;
  assign owner_valid = (state_q == ST_OWN);
  assign owner_idx   = last_owner_q;
  assign led_out     = led_out_q;
endmodule
